// File: rtl/dsp_simd_pair_scheduler.sv
// Round-robin scheduler that shares one fractured 8x8 SIMD DSP multiplier between N_REQ requesters.
// Define DSP_SIMD_PAIR_EN to build dual-lane issue; otherwise only lane 0 is used.
module dsp_simd_pair_scheduler #(
    parameter int N_REQ   = 4,
    parameter int DSP_LAT = 1
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [8*N_REQ-1:0]   req_a_i,
    input  logic [8*N_REQ-1:0]   req_b_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic [7:0]           dsp_a0_o,
    output logic [7:0]           dsp_b0_o,
    output logic [7:0]           dsp_a1_o,
    output logic [7:0]           dsp_b1_o,
    output logic                 dsp_simd_o,
    input  logic [15:0]          dsp_z0_i,
    input  logic [15:0]          dsp_z1_i,
    output logic [N_REQ-1:0]     rsp_valid_o,
    output logic [16*N_REQ-1:0]  rsp_z_o,
    output logic                 busy_o
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    typedef logic [IW-1:0] idx_t;

    // Handshake: a requester is served on the rising edge where req_valid_i and
    // req_ready_o are both high; ready is only ever raised to a valid requester.

    function automatic idx_t wrap_add(input idx_t base, input logic [IW:0] off);
        logic [IW:0] sum;
        sum = {1'b0, base} + off;
        if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
        return sum[IW-1:0];
    endfunction

    logic [7:0]  a_arr [N_REQ];
    logic [7:0]  b_arr [N_REQ];
    idx_t        ptr_q, ptr_d;
    idx_t        cand;
    logic        g0_vld;
    idx_t        g0_idx;
    logic [7:0]  dsp_a0_q, dsp_a0_d, dsp_b0_q, dsp_b0_d;
    logic [DSP_LAT:0] t0_vld_q, t0_vld_d;
    idx_t        t0_idx_q [DSP_LAT+1];
    idx_t        t0_idx_d [DSP_LAT+1];
    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_z_q [N_REQ];
    logic [15:0] rsp_z_d [N_REQ];
`ifdef DSP_SIMD_PAIR_EN
    logic        g1_vld;
    idx_t        g1_idx;
    logic [7:0]  dsp_a1_q, dsp_a1_d, dsp_b1_q, dsp_b1_d;
    logic [DSP_LAT:0] t1_vld_q, t1_vld_d;
    idx_t        t1_idx_q [DSP_LAT+1];
    idx_t        t1_idx_d [DSP_LAT+1];
`else
    logic        unused_z1;
    assign unused_z1 = ^dsp_z1_i;
`endif

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            a_arr[k] = req_a_i[8*k +: 8];
            b_arr[k] = req_b_i[8*k +: 8];
        end
    end

    // Scan from ptr: first valid requester takes lane 0, second takes lane 1.
    always_comb begin
        cand   = '0;
        g0_vld = 1'b0;
        g0_idx = '0;
`ifdef DSP_SIMD_PAIR_EN
        g1_vld = 1'b0;
        g1_idx = '0;
`endif
        for (int i = 0; i < N_REQ; i++) begin
            cand = wrap_add(ptr_q, (IW+1)'(i));
            if (req_valid_i[cand] && !reset_i) begin
                if (!g0_vld) begin
                    g0_vld = 1'b1;
                    g0_idx = cand;
                end
`ifdef DSP_SIMD_PAIR_EN
                else if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1_idx = cand;
                end
`endif
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        for (int k = 0; k < N_REQ; k++) begin
            req_ready_o[k] = (g0_vld && (g0_idx == idx_t'(k)))
`ifdef DSP_SIMD_PAIR_EN
                           || (g1_vld && (g1_idx == idx_t'(k)))
`endif
                           ;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
`ifdef DSP_SIMD_PAIR_EN
        if (g1_vld) ptr_d = wrap_add(g1_idx, (IW+1)'(1));
        else
`endif
        if (g0_vld) ptr_d = wrap_add(g0_idx, (IW+1)'(1));
    end

    // Ungranted lanes issue zero operands.
    always_comb begin
        dsp_a0_d = g0_vld ? a_arr[g0_idx] : 8'd0;
        dsp_b0_d = g0_vld ? b_arr[g0_idx] : 8'd0;
`ifdef DSP_SIMD_PAIR_EN
        dsp_a1_d = g1_vld ? a_arr[g1_idx] : 8'd0;
        dsp_b1_d = g1_vld ? b_arr[g1_idx] : 8'd0;
`endif
    end

    always_comb begin
        t0_vld_d[0] = g0_vld;
        t0_idx_d[0] = g0_idx;
        for (int s = 1; s <= DSP_LAT; s++) begin
            t0_vld_d[s] = t0_vld_q[s-1];
            t0_idx_d[s] = t0_idx_q[s-1];
        end
`ifdef DSP_SIMD_PAIR_EN
        t1_vld_d[0] = g1_vld;
        t1_idx_d[0] = g1_idx;
        for (int s = 1; s <= DSP_LAT; s++) begin
            t1_vld_d[s] = t1_vld_q[s-1];
            t1_idx_d[s] = t1_idx_q[s-1];
        end
`endif
    end

    // The last tag stage lines up with the DSP result for that lane.
    always_comb begin
        rsp_valid_d = '0;
        for (int k = 0; k < N_REQ; k++) rsp_z_d[k] = rsp_z_q[k];
        if (t0_vld_q[DSP_LAT]) begin
            rsp_valid_d[t0_idx_q[DSP_LAT]] = 1'b1;
            rsp_z_d[t0_idx_q[DSP_LAT]]     = dsp_z0_i;
        end
`ifdef DSP_SIMD_PAIR_EN
        if (t1_vld_q[DSP_LAT]) begin
            rsp_valid_d[t1_idx_q[DSP_LAT]] = 1'b1;
            rsp_z_d[t1_idx_q[DSP_LAT]]     = dsp_z1_i;
        end
`endif
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ptr_q       <= '0;
            dsp_a0_q    <= '0;
            dsp_b0_q    <= '0;
            t0_vld_q    <= '0;
            rsp_valid_q <= '0;
            for (int s = 0; s <= DSP_LAT; s++) t0_idx_q[s] <= '0;
            for (int k = 0; k < N_REQ; k++) rsp_z_q[k] <= '0;
`ifdef DSP_SIMD_PAIR_EN
            dsp_a1_q <= '0;
            dsp_b1_q <= '0;
            t1_vld_q <= '0;
            for (int s = 0; s <= DSP_LAT; s++) t1_idx_q[s] <= '0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            dsp_a0_q    <= dsp_a0_d;
            dsp_b0_q    <= dsp_b0_d;
            t0_vld_q    <= t0_vld_d;
            rsp_valid_q <= rsp_valid_d;
            for (int s = 0; s <= DSP_LAT; s++) t0_idx_q[s] <= t0_idx_d[s];
            for (int k = 0; k < N_REQ; k++) rsp_z_q[k] <= rsp_z_d[k];
`ifdef DSP_SIMD_PAIR_EN
            dsp_a1_q <= dsp_a1_d;
            dsp_b1_q <= dsp_b1_d;
            t1_vld_q <= t1_vld_d;
            for (int s = 0; s <= DSP_LAT; s++) t1_idx_q[s] <= t1_idx_d[s];
`endif
        end
    end

    assign dsp_a0_o    = dsp_a0_q;
    assign dsp_b0_o    = dsp_b0_q;
    assign rsp_valid_o = rsp_valid_q;
`ifdef DSP_SIMD_PAIR_EN
    assign dsp_a1_o   = dsp_a1_q;
    assign dsp_b1_o   = dsp_b1_q;
    assign dsp_simd_o = 1'b1;
    assign busy_o     = (|t0_vld_q) | (|t1_vld_q);
`else
    assign dsp_a1_o   = 8'd0;
    assign dsp_b1_o   = 8'd0;
    assign dsp_simd_o = 1'b0;
    assign busy_o     = |t0_vld_q;
`endif

    always_comb begin
        rsp_z_o = '0;
        for (int k = 0; k < N_REQ; k++) rsp_z_o[16*k +: 16] = rsp_z_q[k];
    end

endmodule

// File: doc/dsp_simd_pair_scheduler.md
# dsp_simd_pair_scheduler

Round-robin scheduler that shares one fractured DSP multiplier (two independent 8x8 unsigned SIMD lanes) between `N_REQ` requesters. Each cycle it grants up to two pending multiply requests, drives them onto the DSP lane operand ports through an issue register, and tracks issued lanes through a fixed-latency tag pipeline. When the DSP result returns, the block routes it back to the owning requester as a one-cycle response pulse. The block sits between requester logic and a `dsp_t1_10x9x32` instance configured for unsigned, non-accumulating, input-registered SIMD multiply.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `DSP_LAT`, 1: cycles from `dsp_a*_o`/`dsp_b*_o` change to a valid `dsp_z*_i` (1..4).

Ports:
- `clock_i`  in  1  single clock; all logic on its rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  N_REQ  per-requester request pending.
- `req_a_i`  in  8*N_REQ  packed operand A; requester k occupies bits [8k+7:8k].
- `req_b_i`  in  8*N_REQ  packed operand B, same packing.
- `req_ready_o`  out  N_REQ  grant; a handshake occurs when valid and ready are both high.
- `dsp_a0_o`, `dsp_b0_o`  out  8 each  lane 0 operands.
- `dsp_a1_o`, `dsp_b1_o`  out  8 each  lane 1 operands.
- `dsp_simd_o`  out  1  DSP fracture-mode select.
- `dsp_z0_i`, `dsp_z1_i`  in  16 each  lane results.
- `rsp_valid_o`  out  N_REQ  one-cycle result pulse per requester.
- `rsp_z_o`  out  16*N_REQ  packed results; requester k occupies bits [16k+15:16k].
- `busy_o`  out  1  high while any issued lane has not yet returned.

## Operation
- **Round-robin pointer `ptr`** (reset value 0):
  - Scan requesters in order `ptr, ptr+1, …` modulo `N_REQ`.
  - The first valid requester found is granted lane 0; the second valid requester found is granted lane 1.
  - After a grant, `ptr` becomes (last granted index + 1) mod `N_REQ`. With no grant, `ptr` holds.
- **Ready rules:**
  - `req_ready_o` is combinational from `req_valid_i` and `ptr`. A requester receives at most one grant per cycle.
  - `req_ready_o` is never asserted to a requester whose valid is low.
- **Issue register:** on a handshake, the granted operands are registered into the `dsp_*` outputs. A lane with no grant is driven with operands 0.
- **Tag pipeline:** one stage per lane per cycle, each holding {valid, requester index}, with depth `DSP_LAT`+1.
  - At the last stage, a valid tag captures `dsp_z0_i` or `dsp_z1_i` into the owning requester's `rsp_z_o` slice and pulses that requester's `rsp_valid_o` bit.
- **No response backpressure.** Requesters must accept results on the pulse.
- **Response ordering:**
  - A requester may have several requests in flight; responses return in issue order because latency is fixed.
  - Both lanes never target the same requester in the same cycle.
- **Output hold:** each `rsp_z_o` slice holds its last value until overwritten.
- **Busy:** `busy_o` is the OR of all valid bits in the tag pipeline.
- **Arithmetic:** unsigned 8x8 multiplication with a 16-bit result. 255*255 = 65025 with no saturation; the result is passed through unmodified.

## Timing
- **Cycle-level latency:**
  - Handshake at edge t.
  - `dsp_*` operands are valid from t+1.
  - `dsp_z*_i` is sampled at t+1+`DSP_LAT`.
  - `rsp_valid_o` is high during cycle t+2+`DSP_LAT`, for exactly one cycle.
- **Throughput:** 2 results per cycle with the SIMD feature compiled in, 1 per cycle without it.
- **Reset values:**
  - All outputs 0: `req_ready_o`, `dsp_*_o`, `rsp_valid_o`, `rsp_z_o`, `busy_o`.
  - Exception: `dsp_simd_o` takes its configured constant.
  - `ptr` is 0 and the tag pipeline is cleared.
- **Reset mid-operation:** all in-flight requests are discarded. No `rsp_valid_o` pulse appears for a request issued before the reset edge, even if its DSP result arrives after reset.
- **During reset:** `req_ready_o` is 0.

## Configuration
- **`DSP_SIMD_PAIR_EN` defined:**
  - Dual-lane issue as described above.
  - `dsp_simd_o` = 1.
- **`DSP_SIMD_PAIR_EN` undefined:**
  - Only lane 0 is granted, so at most one grant per cycle. `ptr` = (lane-0 grant + 1) mod `N_REQ`.
  - `dsp_a1_o`/`dsp_b1_o` are constant 0 and `dsp_z1_i` is ignored.
  - The lane-1 tag pipeline is not built.
  - `dsp_simd_o` = 0.

## Test plan
The bench models the DSP as `DSP_LAT`-cycle-registered products, with `N_REQ`=4 and `DSP_LAT`=1.
- **Reset:** hold `reset_i` for 2 cycles with all valids high -> every output is 0 and `req_ready_o`=0 throughout.
- **Pair issue:**
  - Stimulus: requester 0 with a=3, b=5 and requester 2 with a=255, b=255, both valid at t.
  - Required: `req_ready_o`=4'b0101 at t; at t+1, lane 0 = (3,5) and lane 1 = (255,255).
  - Required: at t+3, `rsp_valid_o`=4'b0101, with z0=15 and z2=65025.
- **Saturated load:** all four valid continuously from `ptr`=0 -> grants alternate {0,1}, {2,3}, {0,1}, …; each requester gets one response every 2 cycles; `busy_o` stays high.
- **Single request:** requester 3 only, a=10, b=20 -> lane 0 = (10,20), lane 1 = (0,0); `ptr` wraps to 0; `rsp_valid_o`=4'b1000 with z3=200.
- **Reset mid-flight:** grant requester 1 at t, then assert `reset_i` at t+1 -> no `rsp_valid_o` pulse through t+6; `busy_o`=0 after reset.
- **`DSP_SIMD_PAIR_EN` undefined:** all four valid -> grants in order 0, 1, 2, 3, 0, one per cycle; lane 1 operands stay 0; `dsp_simd_o`=0.
